ex_mult_div: RTL and testbench



---
 rtl/ex_mult_div_pkg.sv | 25 ++
 rtl/ex_mult_div.sv | 164 ++++++++++++++++
 tb/tb_ex_mult_div.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mult_div_pkg.sv
// ex_mult_div_pkg
//   Shared definitions for the EX-stage multiply/divide unit and the ID-stage
//   hazard logic that has to know about it.
//   - MD_* : encoding of the 3-bit mult/div operation code
//   - MD_MULT_CYCLES / MD_DIV_CYCLES : default busy lengths
//   - md_state_e : two-state sequencing FSM
package ex_mult_div_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/ex_mult_div.sv
// ex_mult_div
//   Multiply/divide unit with architectural HI/LO registers. mult/div results
//   are computed when the operation is accepted, held in a pending latch and
//   committed to HI/LO after a fixed busy period; mthi/mtlo write immediately.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high
//     op     : operation code (MD_* in ex_mult_div_pkg, 7 acts as NONE)
//     src_a  : rs value (multiplicand / dividend / mthi-mtlo data)
//     src_b  : rt value (multiplier / divisor)
//     hi, lo : architectural HI / LO (registered)
//     busy   : mult/div in flight (registered)
module ex_mult_div
    import ex_mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    md_state_e          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic               busy_r;
    logic [31:0]        pend_hi_r;
    logic [31:0]        pend_lo_r;
    logic               pend_wr_r;

    logic               is_mult_s;
    logic               is_div_s;
    logic               is_signed_s;
    logic               is_mthi_s;
    logic               is_mtlo_s;
    logic [63:0]        a_ext_s;
    logic [63:0]        b_ext_s;
    logic [63:0]        prod_s;
    logic               div_zero_s;
    logic signed [32:0] dvd_s;
    logic signed [32:0] dvs_s;
    logic signed [32:0] quot_s;
    logic signed [32:0] rem_s;
    logic               md_unused_s;

    // Decode the operation code into class and signedness.
    always_comb begin
        is_mult_s   = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
        case (op)
            MD_MULT:  begin is_mult_s = 1'b1; is_signed_s = 1'b1; end
            MD_MULTU: begin is_mult_s = 1'b1; end
            MD_DIV:   begin is_div_s  = 1'b1; is_signed_s = 1'b1; end
            MD_DIVU:  begin is_div_s  = 1'b1; end
            MD_MTHI:  begin is_mthi_s = 1'b1; end
            MD_MTLO:  begin is_mtlo_s = 1'b1; end
            default:  begin is_mult_s = 1'b0; end
        endcase
    end

    // Operand extension and arithmetic. 33-bit signed division keeps
    // 0x80000000 / -1 representable (quotient +2^31, low word 0x80000000).
    // A zero divisor is replaced by 1 only to keep the datapath free of X;
    // its result is never committed.
    always_comb begin
        a_ext_s    = {{32{is_signed_s & src_a[31]}}, src_a};
        b_ext_s    = {{32{is_signed_s & src_b[31]}}, src_b};
        prod_s     = a_ext_s * b_ext_s;
        div_zero_s = (src_b == 32'h0000_0000);
        dvd_s      = a_ext_s[32:0];
        if (div_zero_s) begin
            dvs_s = 33'sd1;
        end else begin
            dvs_s = b_ext_s[32:0];
        end
        quot_s = dvd_s / dvs_s;
        rem_s  = dvd_s % dvs_s;
    end

    // Top bits of the 33-bit quotient/remainder are sign bits, not results.
    assign md_unused_s = ^{quot_s[32], rem_s[32]};

    // Sequencing FSM: accept, count down the busy period, commit HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            hi_r      <= 32'h0000_0000;
            lo_r      <= 32'h0000_0000;
            busy_r    <= 1'b0;
            pend_hi_r <= 32'h0000_0000;
            pend_lo_r <= 32'h0000_0000;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_mult_s) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= MULT_LOAD;
                        busy_r    <= 1'b1;
                        pend_hi_r <= prod_s[63:32];
                        pend_lo_r <= prod_s[31:0];
                        pend_wr_r <= 1'b1;
                    end else if (is_div_s) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= DIV_LOAD;
                        busy_r    <= 1'b1;
                        pend_hi_r <= rem_s[31:0];
                        pend_lo_r <= quot_s[31:0];
                        pend_wr_r <= ~div_zero_s;
                    end else if (is_mthi_s) begin
                        hi_r <= src_a;
                    end else if (is_mtlo_s) begin
                        lo_r <= src_a;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Requests arriving while busy are dropped here.
                    if (cnt_r == CNT_ONE) begin
                        if (pend_wr_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_ex_mult_div.sv
// tb_ex_mult_div
//   Directed self-checking bench for ex_mult_div with hand-computed HI/LO
//   values. Inputs change and outputs are sampled 1 ns after each rising edge,
//   so "cycle k" below means k edges after an operation was presented.
module tb_ex_mult_div;
    import ex_mult_div_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_mult_div dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a mult/div in cycle 0, check busy and unchanged HI/LO during
    // cycles 1..n, then the committed values in cycle n+1.
    task automatic run_md(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        op = MD_NONE;
        for (int k = 1; k <= n; k++) begin
            chk({tag, "_busy"},   {31'd0, busy}, 32'd1);
            chk({tag, "_hi_old"}, hi, old_hi);
            chk({tag, "_lo_old"}, lo, old_lo);
            tick();
        end
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1;
        op    = MD_NONE;
        src_a = 32'd0;
        src_b = 32'd0;
        tick();
        reset = 1'b0;
        chk("rst_hi",   hi, 32'd0);
        chk("rst_lo",   lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Idle with random operands but op NONE / reserved: nothing changes.
        for (int i = 0; i < 20; i++) begin
            src_a = $urandom;
            src_b = $urandom;
            op    = (i % 2 == 0) ? MD_NONE : 3'd7;
            tick();
            chk("idle_hi",   hi, 32'd0);
            chk("idle_lo",   lo, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        op = MD_NONE;

        run_md("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu",     MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
        run_md("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 5,
               32'h0000_0002, 32'hFFFF_FFFA, 32'h4000_0000, 32'h0000_0000);
        run_md("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10,
               32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_7",    MD_DIVU,  32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);
        run_md("divu_zero", MD_DIVU,  32'd7, 32'd0, 10,
               32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0001, 32'h7FFF_FFFC);
        run_md("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0000, 32'h8000_0000);

        // MTHI then MTLO on consecutive cycles.
        op    = MD_MTHI;
        src_a = 32'h1234_5678;
        tick();
        op    = MD_MTLO;
        src_a = 32'h9ABC_DEF0;
        chk("mthi_hi",   hi, 32'h1234_5678);
        chk("mthi_lo",   lo, 32'h8000_0000);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        tick();
        op = MD_NONE;
        chk("mtlo_hi",   hi, 32'h1234_5678);
        chk("mtlo_lo",   lo, 32'h9ABC_DEF0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // MTLO and a second MULT presented while busy must be dropped.
        op    = MD_MULT;
        src_a = 32'd4;
        src_b = 32'd5;
        tick();
        op = MD_NONE;
        chk("ovl_busy1", {31'd0, busy}, 32'd1);
        tick();
        $display("[TB] note: protocol violation injected (MTLO while busy)");
        op    = MD_MTLO;
        src_a = 32'hDEAD_BEEF;
        tick();
        op    = MD_MULT;
        src_a = 32'd100;
        src_b = 32'd100;
        chk("ovl_lo_kept", lo, 32'h9ABC_DEF0);
        chk("ovl_busy3",   {31'd0, busy}, 32'd1);
        tick();
        op = MD_NONE;
        chk("ovl_busy4", {31'd0, busy}, 32'd1);
        tick();
        chk("ovl_busy5", {31'd0, busy}, 32'd1);
        tick();
        chk("ovl_busy6", {31'd0, busy}, 32'd0);
        chk("ovl_hi",    hi, 32'd0);
        chk("ovl_lo",    lo, 32'd20);

        // Reset in cycle 3 of a DIV abandons it; MULT from cycle 4 is clean.
        op    = MD_MTHI;
        src_a = 32'hCAFE_F00D;
        tick();
        op    = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        tick();
        op = MD_NONE;
        chk("rdiv_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("rdiv_busy2", {31'd0, busy}, 32'd1);
        tick();
        reset = 1'b1;
        chk("rdiv_busy3", {31'd0, busy}, 32'd1);
        chk("rdiv_hi3",   hi, 32'hCAFE_F00D);
        tick();
        reset = 1'b0;
        chk("rdiv_busy4", {31'd0, busy}, 32'd0);
        chk("rdiv_hi4",   hi, 32'd0);
        chk("rdiv_lo4",   lo, 32'd0);
        run_md("rmult", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'd0, 32'd0, 32'h0000_0000, 32'h0000_0001);

        // Back-to-back: second MULT presented in the cycle the first completes.
        run_md("b2b_1", MD_MULT,  32'd6, 32'd7, 5,
               32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_002A);
        run_md("b2b_2", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5,
               32'h0000_0000, 32'h0000_002A, 32'h0000_0001, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
